// File: rtl/mips_mc_controller.sv
// -----------------------------------------------------------------------------
// mips_mc_controller
//
// Moore-style control FSM for a multicycle MIPS datapath. It steps each
// instruction through fetch, decode and the execute/memory/writeback states
// for its opcode. It drives the datapath mux selects, the write strobes and
// the ALU control code.
//
// Parameters
//   EN_ADDI   : 1 decodes ADDI (001000); 0 treats it as an illegal opcode
//   EN_BNE    : 1 decodes BNE  (000101); 0 treats it as an illegal opcode
//   MEM_WAIT  : 1 honours mem_ready; 0 treats memory as always ready
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-low reset
//   op, funct    : instruction register opcode / function fields
//   zero         : ALU zero flag (used by BEQ/BNE)
//   mem_ready    : memory access completion
//   pc_en, iord, mem_read, mem_write, ir_write, memtoreg, regdst,
//   regwrite, alu_src_a   : datapath controls
//   alu_src_b, pc_source  : 2-bit mux selects
//   alu_control           : 3-bit ALU operation code
//   illegal_op            : one-cycle pulse after an undecodable opcode
//   state                 : current FSM state, for debug
// -----------------------------------------------------------------------------
module mips_mc_controller #(
    parameter int EN_ADDI  = 1,
    parameter int EN_BNE   = 1,
    parameter int MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alu_src_a,
    output logic       illegal_op,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_control,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTEXEC   = 4'd6,
        S_RTWB     = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11,
        S_BNE      = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_NONE  = 2'd0,
        ALU_ADD   = 2'd1,
        ALU_SUB   = 2'd2,
        ALU_FUNCT = 2'd3
    } alu_sel_t;

    state_t   cur_state;
    state_t   nxt_state;
    alu_sel_t alu_sel;
    logic     ready;
    logic     decode_illegal;

    // Raw strobes, before the reset gating below.
    logic pc_en_raw;
    logic mem_read_raw;
    logic mem_write_raw;
    logic ir_write_raw;
    logic regwrite_raw;

    // With MEM_WAIT off the memory is treated as single-cycle.
    assign ready = (MEM_WAIT != 0) ? mem_ready : 1'b1;
    assign state = cur_state;

    // State register and the registered illegal-opcode pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state  <= S_FETCH;
            illegal_op <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            illegal_op <= decode_illegal;
        end
    end

    // Next-state logic. decode_illegal marks the DECODE fall-through arc.
    always_comb begin
        nxt_state      = cur_state;
        decode_illegal = 1'b0;
        case (cur_state)
            S_FETCH:    nxt_state = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    6'b100011,
                    6'b101011: nxt_state = S_MEMADR;
                    6'b000000: nxt_state = S_RTEXEC;
                    6'b000100: nxt_state = S_BEQ;
                    6'b000010: nxt_state = S_JUMP;
                    6'b001000: begin
                        if (EN_ADDI != 0) begin
                            nxt_state = S_ADDIEXEC;
                        end else begin
                            nxt_state      = S_FETCH;
                            decode_illegal = 1'b1;
                        end
                    end
                    6'b000101: begin
                        if (EN_BNE != 0) begin
                            nxt_state = S_BNE;
                        end else begin
                            nxt_state      = S_FETCH;
                            decode_illegal = 1'b1;
                        end
                    end
                    default: begin
                        nxt_state      = S_FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   nxt_state = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
            S_MEMRD:    nxt_state = ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:    nxt_state = S_FETCH;
            S_MEMWR:    nxt_state = ready ? S_FETCH : S_MEMWR;
            S_RTEXEC:   nxt_state = S_RTWB;
            S_RTWB:     nxt_state = S_FETCH;
            S_BEQ:      nxt_state = S_FETCH;
            S_ADDIEXEC: nxt_state = S_ADDIWB;
            S_ADDIWB:   nxt_state = S_FETCH;
            S_JUMP:     nxt_state = S_FETCH;
            S_BNE:      nxt_state = S_FETCH;
            default:    nxt_state = S_FETCH;
        endcase
    end

    // Per-state output decode; anything a state does not name stays 0.
    always_comb begin
        pc_en_raw     = 1'b0;
        iord          = 1'b0;
        mem_read_raw  = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        memtoreg      = 1'b0;
        regdst        = 1'b0;
        regwrite_raw  = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        alu_sel       = ALU_NONE;
        case (cur_state)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = 2'b01;
                alu_sel      = ALU_ADD;
                ir_write_raw = ready;
                pc_en_raw    = ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_sel   = ALU_ADD;
            end
            S_MEMADR, S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_sel   = ALU_ADD;
            end
            S_MEMRD: begin
                iord         = 1'b1;
                mem_read_raw = 1'b1;
            end
            S_MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_MEMWR: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_RTEXEC: begin
                alu_src_a = 1'b1;
                alu_sel   = ALU_FUNCT;
            end
            S_RTWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            S_BEQ, S_BNE: begin
                alu_src_a = 1'b1;
                alu_sel   = ALU_SUB;
                pc_source = 2'b01;
                pc_en_raw = (cur_state == S_BEQ) ? zero : ~zero;
            end
            S_ADDIWB: begin
                regwrite_raw = 1'b1;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_en_raw = 1'b1;
            end
            default: begin
                pc_en_raw = 1'b0;
            end
        endcase
    end

    // ALU operation code from the selected ALU op.
    always_comb begin
        alu_control = 3'b000;
        case (alu_sel)
            ALU_ADD: alu_control = 3'b010;
            ALU_SUB: alu_control = 3'b110;
            ALU_FUNCT: begin
                case (funct)
                    6'b100000: alu_control = 3'b010;
                    6'b100010: alu_control = 3'b110;
                    6'b100100: alu_control = 3'b000;
                    6'b100101: alu_control = 3'b001;
                    6'b101010: alu_control = 3'b111;
                    default:   alu_control = 3'b010;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // Strobes are gated by reset so nothing writes while it is held low.
    // The state register is already forced to FETCH, so the other outputs
    // show the FETCH decode.
    assign pc_en     = pc_en_raw & reset;
    assign mem_read  = mem_read_raw & reset;
    assign mem_write = mem_write_raw & reset;
    assign ir_write  = ir_write_raw & reset;
    assign regwrite  = regwrite_raw & reset;

endmodule

// File: tb/tb_mips_mc_controller.sv
// -----------------------------------------------------------------------------
// tb_mips_mc_controller
//
// Testbench for mips_mc_controller. It uses two instances. Instance A has the
// default parameters. Instance B has ADDI and BNE disabled and ignores
// mem_ready. A task builds the expected per-cycle state list for each
// instruction from its opcode and the wait cycles, and a table gives the
// expected outputs for each state.
// -----------------------------------------------------------------------------
module tb_mips_mc_controller;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alu_src_a;
        logic       illegal_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_control;
    } outs_t;

    typedef struct {
        int   st;
        logic rdy;
    } step_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int    nChecks = 0;
    int    nFail   = 0;
    logic  pendingIll = 1'b0;
    step_t plan[$];

    // Instance A signals
    logic       reset_a, zero_a, ready_a;
    logic [5:0] op_a, funct_a;
    logic       pc_en_a, iord_a, mem_read_a, mem_write_a, ir_write_a;
    logic       memtoreg_a, regdst_a, regwrite_a, alu_src_a_a, illegal_op_a;
    logic [1:0] alu_src_b_a, pc_source_a;
    logic [2:0] alu_control_a;
    logic [3:0] state_a;

    // Instance B signals
    logic       reset_b, zero_b, ready_b;
    logic [5:0] op_b, funct_b;
    logic       pc_en_b, iord_b, mem_read_b, mem_write_b, ir_write_b;
    logic       memtoreg_b, regdst_b, regwrite_b, alu_src_a_b, illegal_op_b;
    logic [1:0] alu_src_b_b, pc_source_b;
    logic [2:0] alu_control_b;
    logic [3:0] state_b;

    mips_mc_controller dut_a (
        .clk(clk), .reset(reset_a), .op(op_a), .funct(funct_a),
        .zero(zero_a), .mem_ready(ready_a),
        .pc_en(pc_en_a), .iord(iord_a), .mem_read(mem_read_a),
        .mem_write(mem_write_a), .ir_write(ir_write_a), .memtoreg(memtoreg_a),
        .regdst(regdst_a), .regwrite(regwrite_a), .alu_src_a(alu_src_a_a),
        .illegal_op(illegal_op_a), .alu_src_b(alu_src_b_a),
        .pc_source(pc_source_a), .alu_control(alu_control_a), .state(state_a)
    );

    mips_mc_controller #(.EN_ADDI(0), .EN_BNE(0), .MEM_WAIT(0)) dut_b (
        .clk(clk), .reset(reset_b), .op(op_b), .funct(funct_b),
        .zero(zero_b), .mem_ready(ready_b),
        .pc_en(pc_en_b), .iord(iord_b), .mem_read(mem_read_b),
        .mem_write(mem_write_b), .ir_write(ir_write_b), .memtoreg(memtoreg_b),
        .regdst(regdst_b), .regwrite(regwrite_b), .alu_src_a(alu_src_a_b),
        .illegal_op(illegal_op_b), .alu_src_b(alu_src_b_b),
        .pc_source(pc_source_b), .alu_control(alu_control_b), .state(state_b)
    );

    function automatic logic [2:0] functCode(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs per state, straight from the state output table.
    function automatic outs_t expOut(input int st, input logic [5:0] fn,
                                     input logic z, input logic rdyEff,
                                     input logic ill, input logic inRst);
        outs_t o = '0;
        case (st)
            0:  begin o.mem_read = 1; o.alu_src_b = 2'b01; o.alu_control = 3'b010;
                      o.ir_write = rdyEff; o.pc_en = rdyEff; end
            1:  begin o.alu_src_b = 2'b11; o.alu_control = 3'b010; end
            2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
            3:  begin o.iord = 1; o.mem_read = 1; end
            4:  begin o.memtoreg = 1; o.regwrite = 1; end
            5:  begin o.iord = 1; o.mem_write = 1; end
            6:  begin o.alu_src_a = 1; o.alu_control = functCode(fn); end
            7:  begin o.regdst = 1; o.regwrite = 1; end
            8:  begin o.alu_src_a = 1; o.alu_control = 3'b110; o.pc_source = 2'b01; o.pc_en = z; end
            9:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_control = 3'b010; end
            10: begin o.regwrite = 1; end
            11: begin o.pc_source = 2'b10; o.pc_en = 1; end
            12: begin o.alu_src_a = 1; o.alu_control = 3'b110; o.pc_source = 2'b01; o.pc_en = ~z; end
            default: o = '0;
        endcase
        o.illegal_op = ill;
        if (inRst) begin
            o.pc_en = 0; o.ir_write = 0; o.regwrite = 0; o.mem_read = 0; o.mem_write = 0;
        end
        return o;
    endfunction

    function automatic outs_t observed(input int which);
        outs_t o;
        if (which == 0)
            o = '{pc_en_a, iord_a, mem_read_a, mem_write_a, ir_write_a, memtoreg_a,
                  regdst_a, regwrite_a, alu_src_a_a, illegal_op_a, alu_src_b_a,
                  pc_source_a, alu_control_a};
        else
            o = '{pc_en_b, iord_b, mem_read_b, mem_write_b, ir_write_b, memtoreg_b,
                  regdst_b, regwrite_b, alu_src_a_b, illegal_op_b, alu_src_b_b,
                  pc_source_b, alu_control_b};
        return o;
    endfunction

    task automatic applyStimulus(input int which, input logic [5:0] op, input logic [5:0] fn,
                                 input logic z, input logic rdy);
        if (which == 0) begin
            op_a = op; funct_a = fn; zero_a = z; ready_a = rdy;
        end else begin
            op_b = op; funct_b = fn; zero_b = z; ready_b = rdy;
        end
    endtask

    task automatic checkOutput(input int which, input string tag, input int expSt, input outs_t exp);
        outs_t      obs = observed(which);
        logic [3:0] os  = (which == 0) ? state_a : state_b;
        nChecks++;
        assert (os === 4'(expSt)) else begin
            nFail++;
            $error("[TB] FAIL %s state: observed %0d expected %0d", tag, os, expSt);
        end
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s outputs (state %0d): observed %05h expected %05h", tag, expSt, obs, exp);
        end
    endtask

    task automatic pushStep(input int st);
        step_t s;
        s.st  = st;
        s.rdy = 1'($urandom_range(0, 1));
        plan.push_back(s);
    endtask

    // A memory phase is waits not-ready cycles and then one ready cycle.
    // Instance B ignores mem_ready, so its phase is always one cycle.
    task automatic pushMem(input int st, input int waits, input int which);
        step_t s;
        s.st = st;
        if (which == 0) begin
            for (int i = 0; i < waits; i++) begin
                s.rdy = 1'b0;
                plan.push_back(s);
            end
            s.rdy = 1'b1;
        end else begin
            s.rdy = 1'($urandom_range(0, 1));
        end
        plan.push_back(s);
    endtask

    // Builds the expected state list for one instruction and steps through it.
    // If abortAt >= 0, reset is pulled low during that step.
    task automatic runInstr(input int which, input string tag, input logic [5:0] op,
                            input logic [5:0] fn, input logic z, input int fetchWait,
                            input int memWait, input int abortAt);
        logic illegalNow = 1'b0;
        logic rdyEff;
        logic ill;
        plan.delete();
        pushMem(0, fetchWait, which);
        pushStep(1);
        case (op)
            OP_LW:   begin pushStep(2); pushMem(3, memWait, which); pushStep(4); end
            OP_SW:   begin pushStep(2); pushMem(5, memWait, which); end
            OP_R:    begin pushStep(6); pushStep(7); end
            OP_BEQ:  pushStep(8);
            OP_J:    pushStep(11);
            OP_ADDI: if (which == 0) begin pushStep(9); pushStep(10); end else illegalNow = 1'b1;
            OP_BNE:  if (which == 0) pushStep(12); else illegalNow = 1'b1;
            default: illegalNow = 1'b1;
        endcase
        foreach (plan[i]) begin
            applyStimulus(which, op, fn, z, plan[i].rdy);
            #2;
            ill    = (i == 0) ? pendingIll : 1'b0;
            rdyEff = (which == 1) ? 1'b1 : plan[i].rdy;
            checkOutput(which, tag, plan[i].st, expOut(plan[i].st, fn, z, rdyEff, ill, 1'b0));
            if (i == abortAt) begin
                #1;
                reset_a = 1'b0;
                #1;
                checkOutput(which, {tag, "_rst_now"}, 0, expOut(0, fn, z, plan[i].rdy, 1'b0, 1'b1));
                @(posedge clk); #1;
                checkOutput(which, {tag, "_rst_held"}, 0, expOut(0, fn, z, plan[i].rdy, 1'b0, 1'b1));
                reset_a    = 1'b1;
                pendingIll = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        pendingIll = illegalNow;
    endtask

    task automatic runRandom(input int which, input int count);
        logic [5:0] functs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int k = 0; k < count; k++) begin
            logic [5:0] rop;
            logic [5:0] rfn;
            case ($urandom_range(0, 8))
                0: rop = OP_LW;
                1: rop = OP_SW;
                2: rop = OP_R;
                3: rop = OP_BEQ;
                4: rop = OP_BNE;
                5: rop = OP_J;
                6: rop = OP_ADDI;
                7: rop = 6'($urandom_range(0, 63));
                default: rop = 6'b110011;
            endcase
            if ($urandom_range(0, 5) == 0) rfn = 6'($urandom_range(0, 63));
            else                           rfn = functs[$urandom_range(0, 4)];
            runInstr(which, "rand", rop, rfn, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end
    endtask

    initial begin
        reset_a = 1'b0; reset_b = 1'b0;
        applyStimulus(0, 6'b0, 6'b0, 1'b0, 1'b0);
        applyStimulus(1, 6'b0, 6'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput(0, "reset_a", 0, expOut(0, 6'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        checkOutput(1, "reset_b", 0, expOut(0, 6'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        reset_a = 1'b1;

        // Directed sequence on instance A.
        runInstr(0, "lw",       OP_LW,   6'b0,      1'b0, 0, 0, -1);
        runInstr(0, "sw_wait3", OP_SW,   6'b0,      1'b0, 0, 3, -1);
        runInstr(0, "rtype_slt", OP_R,   6'b101010, 1'b0, 0, 0, -1);
        runInstr(0, "beq_z1",   OP_BEQ,  6'b0,      1'b1, 0, 0, -1);
        runInstr(0, "bne_z1",   OP_BNE,  6'b0,      1'b1, 0, 0, -1);
        runInstr(0, "beq_z0",   OP_BEQ,  6'b0,      1'b0, 0, 0, -1);
        runInstr(0, "bne_z0",   OP_BNE,  6'b0,      1'b0, 0, 0, -1);
        runInstr(0, "jump",     OP_J,    6'b0,      1'b0, 2, 0, -1);
        runInstr(0, "addi",     OP_ADDI, 6'b0,      1'b0, 0, 0, -1);
        runInstr(0, "illegal",  6'b111111, 6'b0,    1'b0, 0, 0, -1);
        runInstr(0, "after_ill", OP_R,   6'b100100, 1'b0, 1, 0, -1);
        runRandom(0, 40);

        // Reset pulled during the second MEMRD wait cycle of a lw.
        runInstr(0, "lw_abort", OP_LW,   6'b0,      1'b0, 0, 3, 4);
        runInstr(0, "resume",   OP_LW,   6'b0,      1'b0, 1, 1, -1);

        // Switch to instance B: ADDI/BNE disabled, memory never waits.
        reset_a = 1'b0;
        reset_b = 1'b1;
        pendingIll = 1'b0;
        runInstr(1, "b_addi_ill", OP_ADDI, 6'b0,    1'b0, 0, 0, -1);
        runInstr(1, "b_after",    OP_R,  6'b100101, 1'b0, 0, 0, -1);
        runInstr(1, "b_bne_ill",  OP_BNE, 6'b0,     1'b1, 0, 0, -1);
        runInstr(1, "b_lw",       OP_LW,  6'b0,     1'b0, 0, 0, -1);
        runRandom(1, 30);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 SHALL have parameter EN_ADDI, default 1; 1 decodes ADDI (opcode 001000), 0 treats it as illegal.
REQ-002 SHALL have parameter EN_BNE, default 1; 1 decodes BNE (opcode 000101), 0 treats it as illegal.
REQ-003 SHALL have parameter MEM_WAIT, default 1; 1 honours mem_ready, 0 treats mem_ready as constant 1.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have inputs op[5:0] and funct[5:0] (instruction register fields), zero (ALU zero flag) and mem_ready (1-bit memory completion).
REQ-007 SHALL have 1-bit outputs pc_en, iord, mem_read, mem_write, ir_write, memtoreg, regdst, regwrite, alu_src_a and illegal_op.
REQ-008 SHALL have outputs alu_src_b[1:0], pc_source[1:0], alu_control[2:0] and state[3:0] (current state, for debug).

Function
REQ-009 SHALL be a Moore FSM with 4-bit state encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEXEC=6, RTWB=7, BEQ=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, BNE=12.
REQ-010 SHALL drive every output not listed for a state to 0.
REQ-011 SHALL make ALU op "add" give alu_control=010 and "sub" give 110.
REQ-012 SHALL make ALU op "funct" decode: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
REQ-013 FETCH SHALL assert mem_read and alu_src_b=01 with ALU add; ir_write and pc_en equal the effective mem_ready.
REQ-014 FETCH SHALL go to DECODE on effective mem_ready=1, otherwise hold in FETCH.
REQ-015 DECODE SHALL assert alu_src_b=11 with ALU add.
REQ-016 DECODE SHALL branch on op: 100011/101011->MEMADR, 000000->RTEXEC, 000100->BEQ, 000010->JUMP, 001000->ADDIEXEC (if EN_ADDI), 000101->BNE (if EN_BNE), else->FETCH.
REQ-017 MEMADR SHALL assert alu_src_a=1 and alu_src_b=10 with ALU add, then go to MEMRD if op=100011, else MEMWR.
REQ-018 MEMRD SHALL assert iord and mem_read, and hold until effective mem_ready, then go to MEMWB.
REQ-019 MEMWB SHALL assert memtoreg and regwrite with regdst=0, then go to FETCH.
REQ-020 MEMWR SHALL assert iord and mem_write, and hold until effective mem_ready, then go to FETCH.
REQ-021 RTEXEC SHALL assert alu_src_a=1 and alu_src_b=00 with ALU funct, then go to RTWB; RTWB SHALL assert regdst and regwrite, then go to FETCH.
REQ-022 BEQ SHALL assert alu_src_a=1 and alu_src_b=00 with ALU sub and pc_source=01, drive pc_en=zero, then go to FETCH.
REQ-023 BNE SHALL match BEQ except pc_en=~zero.
REQ-024 ADDIEXEC SHALL assert alu_src_a=1 and alu_src_b=10 with ALU add, then go to ADDIWB; ADDIWB SHALL assert regwrite with regdst=0, then go to FETCH.
REQ-025 JUMP SHALL assert pc_source=10 and pc_en=1, then go to FETCH.
REQ-026 SHALL register illegal_op as a 1-cycle pulse in the cycle after a DECODE that takes the else->FETCH arc.
REQ-027 SHALL keep all outputs stable, and assert no write strobe except the state's own, while holding for mem_ready.
REQ-028 SHALL give instruction latencies with zero wait: lw 5, sw 4, R-type 4, ADDI 4, BEQ/BNE 3, J 3, illegal 2 cycles.
REQ-029 SHALL extend each of FETCH, MEMRD and MEMWR by one cycle per cycle that mem_ready=0, when MEM_WAIT=1.

Reset
REQ-030 SHALL force state to FETCH and illegal_op to 0 immediately while reset=0, regardless of clk.
REQ-031 SHALL force pc_en, ir_write, regwrite, mem_read and mem_write to 0 while reset=0; all other outputs follow FETCH decode (alu_src_b=01, alu_control=010).
REQ-032 SHALL abandon the current instruction when reset is asserted mid-instruction, in any state including a mem_ready wait, with no write strobe after assertion.
REQ-033 SHALL start FETCH on the first rising clk edge after reset deasserts.

Verification
REQ-034 SHALL cover lw, op=100011 with mem_ready=1: states 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
REQ-035 SHALL cover sw with mem_ready held 0 for 3 cycles in MEMWR: MEMWR lasts 4 cycles with mem_write=1 throughout, then FETCH.
REQ-036 SHALL cover R-type, funct=101010: alu_control=111 in RTEXEC; regdst=1 and regwrite=1 in RTWB.
REQ-037 SHALL cover BEQ and BNE with zero=1: BEQ gives pc_en=1, pc_source=01; BNE gives pc_en=0; with zero=0 the results invert.
REQ-038 SHALL cover EN_ADDI=0 with op=001000: DECODE->FETCH, illegal_op=1 for exactly one cycle, no regwrite.
REQ-039 SHALL cover reset=0 asserted in MEMRD while waiting: state=0 and mem_read=0 immediately; FETCH resumes after release.
